regfile_mp: RTL and testbench

//   Parametrised multi-port integer register file with an integrated pending-write scoreboard.
//   It provides NRD asynchronous read ports and NWR write ports, an optional hard-wired zero

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int ZERO_IDX = 0;

  function automatic int calc_aw(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations from decode and
// cleared by writeback; a reservation on the same edge as a write keeps the bit set.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] wr_clr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] pending,
  output logic             busy_any
);

  logic [NREGS-1:0] rsv_dec_s;
  logic [NREGS-1:0] pend_next_s;
  logic [NREGS-1:0] pending_r;
  logic             busy_any_r;

  // Decode the reservation; the hard-wired zero register never becomes pending.
  always_comb begin
    rsv_dec_s = '0;
    if (rsv_en && !((ZERO_REG != 0) && (rsv_addr == AW'(ZERO_IDX)))) begin
      rsv_dec_s[rsv_addr] = 1'b1;
    end else begin
      rsv_dec_s = '0;
    end
  end

  // A newer producer outranks the retiring one, so reserve is applied after the clear.
  always_comb begin
    pend_next_s = (pending_r & ~wr_clr) | rsv_dec_s;
  end

  // Pending state and its registered OR-reduction for drain checks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r  <= '0;
      busy_any_r <= 1'b0;
    end else begin
      pending_r  <= pend_next_s;
      busy_any_r <= |pend_next_s;
    end
  end

  assign pending  = pending_r;
  assign busy_any = busy_any_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional zero register, optional write-to-read
// bypass and an integrated pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                busy_any
);

  logic [XLEN-1:0]  regs_r    [NREGS];
  logic [XLEN-1:0]  wr_data_s [NREGS];
  logic [NREGS-1:0] wr_hit_s;
  logic [NWR-1:0]   we_eff_s;
  logic [NREGS-1:0] pending_s;
  logic [AW-1:0]    rd_idx_s  [NRD];

  // Drop writes aimed at the hard-wired zero register.
  always_comb begin
    we_eff_s = '0;
    for (int k = 0; k < NWR; k++) begin
      we_eff_s[k] = we[k] && !((ZERO_REG != 0) && (wa[k*AW +: AW] == AW'(ZERO_IDX)));
    end
  end

  // Per-register write select; later ports override earlier ones, so the highest index wins.
  always_comb begin
    wr_hit_s = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_data_s[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        wr_data_s[r] = (we_eff_s[k] && (wa[k*AW +: AW] == AW'(r))) ? wd[k*XLEN +: XLEN]
                                                                  : wr_data_s[r];
        wr_hit_s[r]  = wr_hit_s[r] | (we_eff_s[k] && (wa[k*AW +: AW] == AW'(r)));
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit_s[r]) begin
          regs_r[r] <= wr_data_s[r];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_clr   (wr_hit_s),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pending  (pending_s),
    .busy_any (busy_any)
  );

  // Read ports; a bypassed value is by definition no longer pending from this producer.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_idx_s[i] = ra[i*AW +: AW];
      if (rst) begin
        rd[i*XLEN +: XLEN] = '0;
        rd_busy[i]         = 1'b0;
      end else if ((ZERO_REG != 0) && (rd_idx_s[i] == AW'(ZERO_IDX))) begin
        rd[i*XLEN +: XLEN] = '0;
        rd_busy[i]         = 1'b0;
      end else if ((BYPASS != 0) && wr_hit_s[rd_idx_s[i]]) begin
        rd[i*XLEN +: XLEN] = wr_data_s[rd_idx_s[i]];
        rd_busy[i]         = 1'b0;
      end else begin
        rd[i*XLEN +: XLEN] = regs_r[rd_idx_s[i]];
        rd_busy[i]         = pending_s[rd_idx_s[i]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two register files (bypass on/off) driven in lockstep and compared
// every cycle against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [NRD*XLEN-1:0] rd_b, rd_n;
  logic [NRD-1:0]      busy_b, busy_n;
  logic                any_b, any_n;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b), .rd_busy(busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(any_b));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_n), .rd_busy(busy_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_any(any_n));

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] rdb;
    logic [NRD*XLEN-1:0] rdn;
    logic [NRD-1:0]      bb;
    logic [NRD-1:0]      bn;
    logic                any;
    int                  id;
  } exp_t;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];
  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", nm, id, act, exp);
    end
  endtask

  // Highest write port targeting register a this cycle, -1 if none.
  function automatic int writer(input int a);
    int w = -1;
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && int'(wa[k*AW +: AW]) == a) w = k;
    end
    return w;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int a, input bit byp);
    int w = writer(a);
    if (rst || a == 0) return '0;
    if (byp && w >= 0) return wd[w*XLEN +: XLEN];
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (rst) return 1'b0;
    if (byp && writer(a) >= 0) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic push_expect();
    exp_t e;
    int   a;
    e.rdb = '0; e.rdn = '0; e.bb = '0; e.bn = '0; e.any = 1'b0; e.id = cyc;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end
    for (int i = 0; i < NRD; i++) begin
      a = int'(ra[i*AW +: AW]);
      e.rdb[i*XLEN +: XLEN] = exp_rd(a, 1'b1);
      e.rdn[i*XLEN +: XLEN] = exp_rd(a, 1'b0);
      e.bb[i] = exp_busy(a, 1'b1);
      e.bn[i] = exp_busy(a, 1'b0);
    end
    for (int r = 0; r < NREGS; r++) e.any = e.any | m_pend[r];
    sbq.push_back(e);
  endtask

  // Clock-edge effect on the model: writes in port order, then reservation.
  task automatic model_edge();
    int a;
    if (!rst) begin
      for (int k = 0; k < NWR; k++) begin
        a = int'(wa[k*AW +: AW]);
        if (we[k] && a != 0) begin
          m_regs[a] = wd[k*XLEN +: XLEN];
          m_pend[a] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 5'd0) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_edge();
    #2;
    cyc++;
  endtask

  task automatic set_w(input int k, input bit en, input int a, input logic [31:0] d);
    we[k] = en;
    wa[k*AW +: AW] = AW'(a);
    wd[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_ra(input int i, input int a);
    ra[i*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    we = '0;
    rsv_en = 1'b0;
  endtask

  // Monitor: outputs are sampled mid-cycle, well away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < NRD; i++) begin
          chk($sformatf("rd_byp[%0d]", i), e.id, rd_b[i*XLEN +: XLEN], e.rdb[i*XLEN +: XLEN]);
          chk($sformatf("rd_nobyp[%0d]", i), e.id, rd_n[i*XLEN +: XLEN], e.rdn[i*XLEN +: XLEN]);
        end
        chk("rd_busy_byp", e.id, 32'(busy_b), 32'(e.bb));
        chk("rd_busy_nobyp", e.id, 32'(busy_n), 32'(e.bn));
        chk("busy_any_byp", e.id, 32'(any_b), 32'(e.any));
        chk("busy_any_nobyp", e.id, 32'(any_n), 32'(e.any));
      end
    end
  end

  initial begin
    rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; rsv_en = 1'b0; rsv_addr = '0;
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    @(posedge clk); #2;
    cycle();
    rst = 1'b0;
    cycle();

    // Fill every register with all-ones, reserving x9 along the way.
    for (int r = 0; r < NREGS; r += 2) begin
      set_w(0, 1'b1, r, 32'hFFFF_FFFF);
      set_w(1, 1'b1, r + 1, 32'hFFFF_FFFF);
      set_ra(0, r); set_ra(1, r + 1);
      rsv_en = (r == 8); rsv_addr = 5'd9;
      cycle();
    end
    idle(); set_ra(0, 31); set_ra(1, 9);
    cycle();
    // Reset asserted mid-cycle with writes and a reservation present.
    rst = 1'b1; set_w(0, 1'b1, 4, 32'h1111_1111); set_w(1, 1'b1, 5, 32'h2222_2222);
    rsv_en = 1'b1; rsv_addr = 5'd6; set_ra(0, 4); set_ra(1, 9);
    cycle();
    rst = 1'b0; idle();
    for (int r = 0; r < NREGS; r += 2) begin
      set_ra(0, r); set_ra(1, r + 1);
      cycle();
    end

    // Zero register: write and reservation both ignored.
    rsv_en = 1'b1; rsv_addr = 5'd4; cycle();
    idle(); set_w(0, 1'b1, 0, 32'hDEAD_BEEF); rsv_en = 1'b1; rsv_addr = 5'd0;
    set_ra(0, 0); set_ra(1, 4);
    cycle();
    idle(); cycle();

    // Bypass vs. no bypass.
    set_w(0, 1'b1, 5, 32'h1234_5678); set_ra(0, 5); set_ra(1, 6);
    cycle();
    idle(); cycle();

    // Same-address write collision.
    set_w(0, 1'b1, 7, 32'h0000_0001); set_w(1, 1'b1, 7, 32'h0000_0002);
    set_ra(0, 7); set_ra(1, 7);
    cycle();
    idle(); cycle();

    // Scoreboard: reserve, clear by write, reserve+write same edge.
    rsv_en = 1'b1; rsv_addr = 5'd3; set_ra(0, 3); set_ra(1, 4);
    cycle();
    idle(); cycle();
    set_w(0, 1'b1, 3, 32'hA5A5_0003); set_w(1, 1'b1, 4, 32'h5A5A_0004);
    cycle();
    idle(); cycle();
    set_w(0, 1'b1, 3, 32'h0000_0033); rsv_en = 1'b1; rsv_addr = 5'd3;
    cycle();
    idle(); cycle();

    // Randomised traffic, biased toward a few registers to provoke collisions.
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < NWR; k++) begin
        set_w(k, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1),
              $urandom);
      end
      for (int i = 0; i < NRD; i++) begin
        set_ra(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
      end
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 7));
      cycle();
    end
    rst = 1'b0; idle();

    for (int t = 0; t < 20 && sbq.size() != 0; t++) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
